// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Bus-mapped PWM input capture; measures period and high time
//               in clk cycles between consecutive rising edges of pwm_in.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pwm_in,
  output logic        irq
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_s1, r_s2, r_s3;
  logic              r_en, r_irq_en;
  logic              r_valid, r_ovf;
  logic [CNT_W-1:0]  r_period, r_high;
  logic [CNT_W-1:0]  r_per_cnt, r_hi_cnt;
  logic [CNT_W-1:0]  w_per_nxt, w_hi_nxt;
  logic              w_latch, w_ovf_set;
  logic              w_rise;
  logic              w_wr_ctrl, w_wr_stat;
  wire               w_unused_ok = ^{addr[31:4], addr[1:0], wdata[31:2]};

  assign w_rise    = r_s2 & ~r_s3;
  assign w_wr_ctrl = wr & cs & (addr[3:2] == 2'd0);
  assign w_wr_stat = wr & cs & (addr[3:2] == 2'd1);
  assign irq       = r_valid & r_irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The registered enable gates the FSM, so a rise coinciding with a
  // disabling write is still latched before the return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per_cnt;
    w_hi_nxt    = r_hi_cnt;
    w_latch     = 1'b0;
    w_ovf_set   = 1'b0;
    if (!r_en) begin
      w_state_nxt = S_IDLE;
      w_per_nxt   = '0;
      w_hi_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_per_nxt = '0;
          w_hi_nxt  = '0;
          if (w_rise) begin
            w_state_nxt = S_MEAS;
            w_per_nxt   = C_CNT_ONE;
            w_hi_nxt    = C_CNT_ONE;
          end
        end
        S_MEAS: begin
          if (w_rise) begin
            w_latch   = 1'b1;
            w_per_nxt = C_CNT_ONE;
            w_hi_nxt  = C_CNT_ONE;
          end else if (r_per_cnt == C_CNT_MAX) begin
            w_ovf_set   = 1'b1;
            w_state_nxt = S_IDLE;
            w_per_nxt   = '0;
            w_hi_nxt    = '0;
          end else begin
            w_per_nxt = r_per_cnt + C_CNT_ONE;
            w_hi_nxt  = r_hi_cnt + CNT_W'(r_s2);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_per_nxt   = '0;
          w_hi_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else begin
      r_s1      <= pwm_in;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_per_cnt <= w_per_nxt;
      r_hi_cnt  <= w_hi_nxt;
      if (w_latch) begin
        r_period <= r_per_cnt;
        r_high   <= r_hi_cnt;
      end
      if (w_wr_ctrl) begin
        r_en     <= wdata[0];
        r_irq_en <= wdata[1];
      end
      // Hardware set takes priority over a simultaneous W1C clear.
      r_valid <= w_latch   | (r_valid & ~(w_wr_stat & wdata[0]));
      r_ovf   <= w_ovf_set | (r_ovf   & ~(w_wr_stat & wdata[1]));
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0:    rdata = {30'd0, r_irq_en, r_en};
      2'd1:    rdata = {30'd0, r_ovf, r_valid};
      2'd2:    rdata = 32'(r_period);
      default: rdata = 32'(r_high);
    endcase
  end

endmodule
`default_nettype wire
